// File: rtl/window_scan_ctrl_pkg.sv
// Shared types and size derivations for the sliding-window scan controller.
// Used by the controller RTL and its bench.
package window_scan_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    CONV,
    NEXT
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

  function automatic int pitch_of(input int w, input int k);
    return w + k - 1;
  endfunction

  function automatic int out_dim(input int n, input int s);
    return (n - 1) / s + 1;
  endfunction

  function automatic int addr_width(
    input int base,
    input int h,
    input int k,
    input int pitch
  );
    int w;
    w = clog2(base + (h + k - 1) * pitch);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int idx_width(input int n);
    int w;
    w = clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/window_scan_ctrl_valid_delay.sv
// Fixed-depth 1-bit valid pipeline with synchronous clear.
// Aligns read-valid with memory read data.
module valid_delay #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (clr) begin
      sr <= '0;
    end else begin
      sr[0] <= din;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/window_scan_ctrl.sv
// Raster scan of KxK windows over a padded image held in a pixel memory.
// Issues reads, aligns read data, and hands each window to a convolver.
module window_scan_ctrl
  import window_scan_ctrl_pkg::*;
#(
  parameter int IMG_W     = 128,
  parameter int IMG_H     = 128,
  parameter int K         = 3,
  parameter int STRIDE    = 1,
  parameter int RD_LAT    = 1,
  parameter int BASE_ADDR = 0,
  localparam int PITCH  = pitch_of(IMG_W, K),
  localparam int OUT_W  = out_dim(IMG_W, STRIDE),
  localparam int OUT_H  = out_dim(IMG_H, STRIDE),
  localparam int ADDR_W = addr_width(BASE_ADDR, IMG_H, K, PITCH),
  localparam int ROW_W  = idx_width(OUT_H),
  localparam int COL_W  = idx_width(OUT_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              done_conv,
  output logic [ADDR_W-1:0] addr,
  output logic              rd_en,
  output logic              shift_en,
  output logic              start_conv,
  output logic              busy,
  output logic              done,
  output logic [ROW_W-1:0]  out_row,
  output logic [COL_W-1:0]  out_col
);

  typedef logic [ADDR_W-1:0] addr_t;

  localparam logic [2:0] KM1 = 3'(K - 1);
  localparam logic [2:0] LM1 = 3'(RD_LAT - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_H - 1);

  state_t           state;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [2:0]       dx;
  logic [2:0]       dy;
  logic [2:0]       lat_cnt;
  logic             flush;

  // Full-width address math; operands widened before multiply.
  function automatic addr_t win_addr(
    input logic [ROW_W-1:0] r,
    input logic [COL_W-1:0] c,
    input logic [2:0]       y,
    input logic [2:0]       x
  );
    return addr_t'(BASE_ADDR)
         + (addr_t'(r) * addr_t'(STRIDE) + addr_t'(y))
           * addr_t'(PITCH)
         + addr_t'(c) * addr_t'(STRIDE)
         + addr_t'(x);
  endfunction

  assign out_row = row;
  assign out_col = col;
  assign flush   = rst | (abort & (state != IDLE));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      row        <= '0;
      col        <= '0;
      dx         <= '0;
      dy         <= '0;
      lat_cnt    <= '0;
      addr       <= '0;
      rd_en      <= 1'b0;
      start_conv <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (abort && state != IDLE) begin
      state      <= IDLE;
      rd_en      <= 1'b0;
      start_conv <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start && !abort) begin
            row   <= '0;
            col   <= '0;
            dx    <= '0;
            dy    <= '0;
            addr  <= win_addr('0, '0, '0, '0);
            rd_en <= 1'b1;
            busy  <= 1'b1;
            state <= FETCH;
          end
        end
        FETCH: begin
          if (dx == KM1) begin
            dx <= '0;
            if (dy == KM1) begin
              dy      <= '0;
              rd_en   <= 1'b0;
              lat_cnt <= '0;
              state   <= DRAIN;
            end else begin
              dy   <= dy + 3'd1;
              addr <= win_addr(row, col, dy + 3'd1, '0);
            end
          end else begin
            dx   <= dx + 3'd1;
            addr <= win_addr(row, col, dy, dx + 3'd1);
          end
        end
        DRAIN: begin
          if (lat_cnt == LM1) begin
            start_conv <= 1'b1;
            state      <= CONV;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        CONV: begin
          if (done_conv) begin
            start_conv <= 1'b0;
            state      <= NEXT;
          end
        end
        NEXT: begin
          if (col != COL_LAST) begin
            col   <= col + 1'b1;
            addr  <= win_addr(row, col + 1'b1, '0, '0);
            rd_en <= 1'b1;
            state <= FETCH;
          end else if (row != ROW_LAST) begin
            col   <= '0;
            row   <= row + 1'b1;
            addr  <= win_addr(row + 1'b1, '0, '0, '0);
            rd_en <= 1'b1;
            state <= FETCH;
          end else begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  valid_delay #(
    .DEPTH(RD_LAT)
  ) u_shift_dly (
    .clk (clk),
    .clr (flush),
    .din (rd_en),
    .dout(shift_en)
  );

endmodule
